execute_stage: RTL and testbench

Execute stage of the pipelined CPU datapath, directly downstream of the register file: it consumes the two read operands plus decoded control and produces a registered writeback result. It implements the ARM data-processing ALU subset, a persistent NZCV flags register and conditional execution. An iterative multiplier can optionally be compiled in. Valid/ready handshakes on both sides allow the stage to stall the front end and be stalled by writeback.

---
 rtl/execute_stage_pkg.sv | 60 ++++++
 rtl/execute_stage_if.sv | 35 +++
 rtl/execute_stage_shift_add_multiplier.sv | 58 +++++
 rtl/execute_stage.sv | 165 ++++++++++++++++
 tb/tb_execute_stage.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: ARM data-processing opcodes,
// condition codes, the stage FSM encoding, NZCV bit positions and the
// condition-evaluation helper.
// The MUL state exists only when EXECUTE_STAGE_MUL_EN is defined.
package execute_pkg;

    // Bit positions inside the {N,Z,C,V} flags vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

`ifdef EXECUTE_STAGE_MUL_EN
    typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_e;
`else
    typedef enum logic {ST_IDLE = 1'b0} state_e;
`endif

    // True when an instruction with condition field `cond` should execute.
    // The NV encoding (1111) is treated as always.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Handshake bundle of the execute stage.
//   in_*      : instruction from the register-file stage (valid/ready)
//   out_*     : registered result towards writeback (valid/ready)
//   flags     : current NZCV
// master = upstream/writeback side, slave = the execute stage itself.
interface execute_stage_if #(
    parameter int REG_SIZE  = 32,
    parameter int ADDR_SIZE = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_opcode;
    logic [3:0]           in_cond;
    logic                 in_set_flags;
    logic                 in_mul;
    logic [REG_SIZE-1:0]  in_a;
    logic [REG_SIZE-1:0]  in_b;
    logic [ADDR_SIZE-1:0] in_dest;
    logic                 out_valid;
    logic                 out_ready;
    logic [REG_SIZE-1:0]  out_result;
    logic [ADDR_SIZE-1:0] out_dest;
    logic                 out_wr_en;
    logic [3:0]           flags;

    modport master (
        output in_valid, in_opcode, in_cond, in_set_flags, in_mul, in_a, in_b, in_dest, out_ready,
        input  in_ready, out_valid, out_result, out_dest, out_wr_en, flags
    );

    modport slave (
        input  in_valid, in_opcode, in_cond, in_set_flags, in_mul, in_a, in_b, in_dest, out_ready,
        output in_ready, out_valid, out_result, out_dest, out_wr_en, flags
    );
endinterface

// File: rtl/execute_stage_shift_add_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, reset : clock and synchronous active-high reset (aborts a run)
//   start      : load a/b and begin; ignored results from any prior run
//   a, b       : operands
//   done       : high in the last iteration cycle; product valid then
//   product    : low REG_SIZE bits of a*b (valid while done=1)
// Iterations run on the REG_SIZE edges following the start edge.
module shift_add_multiplier
    import execute_pkg::*;
#(
    parameter int REG_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [REG_SIZE-1:0] a,
    input  logic [REG_SIZE-1:0] b,
    output logic                done,
    output logic [REG_SIZE-1:0] product
);
    localparam int CW = (REG_SIZE > 1) ? $clog2(REG_SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(REG_SIZE - 1);

    logic                busy;
    logic [CW-1:0]       count;
    logic [REG_SIZE-1:0] mcand;
    logic [REG_SIZE-1:0] mplier;
    logic [REG_SIZE-1:0] acc;

    // The last partial product is folded in combinationally so the result
    // is ready in the same cycle done is raised.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (count == LAST) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/execute_stage.sv
// Execute stage: ARM data-processing ALU, NZCV flags register and
// conditional execution, with a registered valid/ready result.
//   clk, reset : clock and synchronous active-high reset
//   bus        : execute_stage_if.slave (in_* instruction, out_* result, flags)
// Optional feature macro: EXECUTE_STAGE_MUL_EN adds an iterative multiply
// (REG_SIZE cycles); without it a passing in_mul retires as a no-op.
module execute_stage
    import execute_pkg::*;
#(
    parameter int REG_SIZE  = 32,
    parameter int ADDR_SIZE = 4
) (
    input  logic            clk,
    input  logic            reset,
    execute_stage_if.slave  bus
);
    state_e               state;
    logic [3:0]           flags_q;
    logic                 out_valid_q;
    logic [REG_SIZE-1:0]  out_result_q;
    logic [ADDR_SIZE-1:0] out_dest_q;
    logic                 out_wr_en_q;

    logic                 pass;
    logic                 accept;
    logic [REG_SIZE-1:0]  op_x, op_y, y_eff, logic_res, alu_res;
    logic [REG_SIZE:0]    sum;
    logic                 arith, inv, cin, alu_wr, alu_force;
    logic [3:0]           alu_flags;

    assign bus.in_ready   = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_dest   = out_dest_q;
    assign bus.out_wr_en  = out_wr_en_q;
    assign bus.flags      = flags_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign pass   = cond_pass(bus.in_cond, flags_q);

    // Every arithmetic op is x + (y or ~y) + cin at REG_SIZE+1 bits; the
    // top bit is the carry (NOT borrow for subtracts).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        op_x      = bus.in_a;
        op_y      = bus.in_b;
        inv       = 1'b0;
        cin       = 1'b0;
        arith     = 1'b0;
        alu_wr    = 1'b1;
        alu_force = 1'b0;
        logic_res = '0;
        case (bus.in_opcode)
            OP_AND: logic_res = bus.in_a & bus.in_b;
            OP_EOR: logic_res = bus.in_a ^ bus.in_b;
            OP_SUB: begin arith = 1'b1; inv = 1'b1; cin = 1'b1; end
            OP_RSB: begin arith = 1'b1; inv = 1'b1; cin = 1'b1; op_x = bus.in_b; op_y = bus.in_a; end
            OP_ADD: arith = 1'b1;
            OP_ADC: begin arith = 1'b1; cin = flags_q[FLAG_C]; end
            OP_SBC: begin arith = 1'b1; inv = 1'b1; cin = flags_q[FLAG_C]; end
            OP_RSC: begin arith = 1'b1; inv = 1'b1; cin = flags_q[FLAG_C]; op_x = bus.in_b; op_y = bus.in_a; end
            OP_TST: begin logic_res = bus.in_a & bus.in_b; alu_wr = 1'b0; alu_force = 1'b1; end
            OP_TEQ: begin logic_res = bus.in_a ^ bus.in_b; alu_wr = 1'b0; alu_force = 1'b1; end
            OP_CMP: begin arith = 1'b1; inv = 1'b1; cin = 1'b1; alu_wr = 1'b0; alu_force = 1'b1; end
            OP_CMN: begin arith = 1'b1; alu_wr = 1'b0; alu_force = 1'b1; end
            OP_ORR: logic_res = bus.in_a | bus.in_b;
            OP_MOV: logic_res = bus.in_b;
            OP_BIC: logic_res = bus.in_a & ~bus.in_b;
            default: logic_res = ~bus.in_b;
        endcase

        y_eff   = inv ? ~op_y : op_y;
        sum     = {1'b0, op_x} + {1'b0, y_eff} + {{REG_SIZE{1'b0}}, cin};
        alu_res = arith ? sum[REG_SIZE-1:0] : logic_res;

        // Logical ops keep C and V.
        alu_flags         = flags_q;
        alu_flags[FLAG_N] = alu_res[REG_SIZE-1];
        alu_flags[FLAG_Z] = (alu_res == '0);
        if (arith) begin
            alu_flags[FLAG_C] = sum[REG_SIZE];
            alu_flags[FLAG_V] = (op_x[REG_SIZE-1] == y_eff[REG_SIZE-1]) &&
                                (sum[REG_SIZE-1] != op_x[REG_SIZE-1]);
        end
    end

`ifdef EXECUTE_STAGE_MUL_EN
    logic                 mul_done;
    logic [REG_SIZE-1:0]  mul_product;
    logic [ADDR_SIZE-1:0] mul_dest;
    logic                 mul_set_flags;

    shift_add_multiplier #(.REG_SIZE(REG_SIZE)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && pass && bus.in_mul),
        .a       (bus.in_a),
        .b       (bus.in_b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            state        <= ST_IDLE;
            flags_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_dest_q   <= '0;
            out_wr_en_q  <= 1'b0;
`ifdef EXECUTE_STAGE_MUL_EN
            mul_dest      <= '0;
            mul_set_flags <= 1'b0;
`endif
        end else begin
            // Consumed results drop unless a new one is loaded below.
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (accept) begin
                if (!pass) begin
                    out_valid_q  <= 1'b1;
                    out_result_q <= '0;
                    out_dest_q   <= bus.in_dest;
                    out_wr_en_q  <= 1'b0;
                end else if (bus.in_mul) begin
`ifdef EXECUTE_STAGE_MUL_EN
                    state         <= ST_MUL;
                    mul_dest      <= bus.in_dest;
                    mul_set_flags <= bus.in_set_flags;
`else
                    out_valid_q  <= 1'b1;
                    out_result_q <= '0;
                    out_dest_q   <= bus.in_dest;
                    out_wr_en_q  <= 1'b0;
`endif
                end else begin
                    out_valid_q  <= 1'b1;
                    out_result_q <= alu_res;
                    out_dest_q   <= bus.in_dest;
                    out_wr_en_q  <= alu_wr;
                    if (bus.in_set_flags || alu_force) begin
                        flags_q <= alu_flags;
                    end
                end
            end
`ifdef EXECUTE_STAGE_MUL_EN
            else if (state == ST_MUL && mul_done) begin
                state        <= ST_IDLE;
                out_valid_q  <= 1'b1;
                out_result_q <= mul_product;
                out_dest_q   <= mul_dest;
                out_wr_en_q  <= 1'b1;
                if (mul_set_flags) begin
                    flags_q[FLAG_N] <= mul_product[REG_SIZE-1];
                    flags_q[FLAG_Z] <= (mul_product == '0);
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage. Expected values are hand-computed.
// Handles both builds: MUL expectations follow EXECUTE_STAGE_MUL_EN.
module tb_execute_stage;
    import execute_pkg::*;

    localparam int REG_SIZE  = 32;
    localparam int ADDR_SIZE = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    execute_stage_if #(.REG_SIZE(REG_SIZE), .ADDR_SIZE(ADDR_SIZE)) bus ();

    execute_stage #(.REG_SIZE(REG_SIZE), .ADDR_SIZE(ADDR_SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] cond, input logic s,
                         input logic mul, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] dest);
        bus.in_valid     = 1'b1;
        bus.in_opcode    = op;
        bus.in_cond      = cond;
        bus.in_set_flags = s;
        bus.in_mul       = mul;
        bus.in_a         = a;
        bus.in_b         = b;
        bus.in_dest      = dest;
    endtask

    task automatic idle();
        bus.in_valid     = 1'b0;
        bus.in_mul       = 1'b0;
        bus.in_set_flags = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic valid, input logic [31:0] res,
                             input logic wr, input logic [3:0] dest, input logic [3:0] nzcv);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(valid));
        check({tag, ".result"}, bus.out_result, res);
        check({tag, ".wr_en"}, 32'(bus.out_wr_en), 32'(wr));
        check({tag, ".dest"}, 32'(bus.out_dest), 32'(dest));
        check({tag, ".flags"}, 32'(bus.flags), 32'(nzcv));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.out_ready = 1'b1;
        drive(OP_AND, COND_AL, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle();

        // Reset state
        repeat (3) step();
        check_out("reset", 1'b0, 32'h0, 1'b0, 4'h0, 4'b0000);
        reset = 1'b0;
        #1;
        check("reset.in_ready", 32'(bus.in_ready), 32'h1);

        // ADD 5+7, S=1
        drive(OP_ADD, COND_AL, 1'b1, 1'b0, 32'd5, 32'd7, 4'd1);
        check("add.pre_valid", 32'(bus.out_valid), 32'h0);
        step();
        check_out("add", 1'b1, 32'd12, 1'b1, 4'd1, 4'b0000);

        // SUB 3-5, S=1: negative, borrow -> C=0
        drive(OP_SUB, COND_AL, 1'b1, 1'b0, 32'd3, 32'd5, 4'd2);
        step();
        check_out("sub", 1'b1, 32'hFFFF_FFFE, 1'b1, 4'd2, 4'b1000);

        // CMP 9,9 then MOV EQ / MOV NE back to back
        drive(OP_CMP, COND_AL, 1'b0, 1'b0, 32'd9, 32'd9, 4'd4);
        check("cmp.in_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("cmp.wr_en", 32'(bus.out_wr_en), 32'h0);
        check("cmp.flags", 32'(bus.flags), 32'(4'b0110));
        drive(OP_MOV, COND_EQ, 1'b0, 1'b0, 32'h0, 32'd1, 4'd3);
        check("moveq.in_ready", 32'(bus.in_ready), 32'h1);
        step();
        check_out("moveq", 1'b1, 32'd1, 1'b1, 4'd3, 4'b0110);
        drive(OP_MOV, COND_NE, 1'b0, 1'b0, 32'h0, 32'd2, 4'd6);
        step();
        check_out("movne", 1'b1, 32'h0, 1'b0, 4'd6, 4'b0110);
        idle();
        step();
        check("drain.valid", 32'(bus.out_valid), 32'h0);

        // Overflowing ADD held by writeback back-pressure
        bus.out_ready = 1'b0;
        drive(OP_ADD, COND_AL, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, 4'd2);
        step();
        check_out("ovf", 1'b1, 32'h8000_0000, 1'b1, 4'd2, 4'b1001);
        drive(OP_ORR, COND_AL, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_000F, 4'd5);
        for (int i = 0; i < 3; i++) begin
            check("hold.in_ready", 32'(bus.in_ready), 32'h0);
            check_out("hold", 1'b1, 32'h8000_0000, 1'b1, 4'd2, 4'b1001);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("release.in_ready", 32'(bus.in_ready), 32'h1);
        step();
        check_out("release", 1'b1, 32'h0000_00FF, 1'b1, 4'd5, 4'b1001);

        // Logical op with S: only N,Z change; C,V held (C=0,V=1)
        drive(OP_EOR, COND_AL, 1'b1, 1'b0, 32'hFF, 32'hFF, 4'd8);
        step();
        check_out("eor", 1'b1, 32'h0, 1'b1, 4'd8, 4'b0101);

        // CMN -1+1: carry out, zero, no overflow
        drive(OP_CMN, COND_AL, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd9);
        step();
        check("cmn.wr_en", 32'(bus.out_wr_en), 32'h0);
        check("cmn.flags", 32'(bus.flags), 32'(4'b0110));

        // RSB 10-2 without S leaves flags
        drive(OP_RSB, COND_AL, 1'b0, 1'b0, 32'd2, 32'd10, 4'd10);
        step();
        check_out("rsb", 1'b1, 32'd8, 1'b1, 4'd10, 4'b0110);

        // ADC 1+1+C(1)
        drive(OP_ADC, COND_AL, 1'b1, 1'b0, 32'd1, 32'd1, 4'd11);
        step();
        check_out("adc", 1'b1, 32'd3, 1'b1, 4'd11, 4'b0000);
        idle();
        step();

        // MUL 6*7, S=1
        drive(OP_AND, COND_AL, 1'b1, 1'b1, 32'd6, 32'd7, 4'd7);
        check("mul.in_ready", 32'(bus.in_ready), 32'h1);
        step();
        idle();
`ifdef EXECUTE_STAGE_MUL_EN
        for (int i = 1; i < REG_SIZE; i++) begin
            check("mul.busy_ready", 32'(bus.in_ready), 32'h0);
            check("mul.busy_valid", 32'(bus.out_valid), 32'h0);
            step();
        end
        check("mul.last_ready", 32'(bus.in_ready), 32'h0);
        check("mul.last_valid", 32'(bus.out_valid), 32'h0);
        step();
        check_out("mul", 1'b1, 32'd42, 1'b1, 4'd7, 4'b0000);
        check("mul.done_ready", 32'(bus.in_ready), 32'h1);
`else
        check_out("mul_off", 1'b1, 32'h0, 1'b0, 4'd7, 4'b0000);
        check("mul_off.in_ready", 32'(bus.in_ready), 32'h1);
`endif
        step();
        check("mul.drain", 32'(bus.out_valid), 32'h0);

        // Reset 10 cycles into a MUL
        drive(OP_SUB, COND_AL, 1'b1, 1'b0, 32'd3, 32'd5, 4'd1);
        step();
        check("abort.pre_flags", 32'(bus.flags), 32'(4'b1000));
        drive(OP_AND, COND_AL, 1'b0, 1'b1, 32'd6, 32'd7, 4'd7);
        step();
        idle();
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_out("abort", 1'b0, 32'h0, 1'b0, 4'h0, 4'b0000);
        check("abort.in_ready", 32'(bus.in_ready), 32'h1);
        for (int i = 0; i < 40; i++) begin
            check("abort.no_output", 32'(bus.out_valid), 32'h0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
